// File: rtl/clk_div_pkg.sv
// Shared constants and the configuration-request record for the multi-channel
// clock divider. Optional phase-realign feature: CLKDIV_SYNC_EN (see clk_div_multi).
package clk_div_pkg;

    localparam int PKG_NCH      = 2;
    localparam int PKG_DIVW     = 16;
    localparam int PKG_DEF_DIV  = 4;
    localparam int PKG_LOCK_CYC = 4;
    localparam int PKG_SYNC_ST  = 2;

    // The request record is sized for the largest supported build
    // (up to 256 channels, divisors up to 32 bits); the top narrows on use.
    localparam int CFG_CHW_MAX  = 8;
    localparam int CFG_DIVW_MAX = 32;

    typedef struct packed {
        logic [CFG_CHW_MAX-1:0]  ch;
        logic [CFG_DIVW_MAX-1:0] div;
    } cfg_req_t;

    function automatic int ch_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/clk_div_chan.sv
// One divider channel: period counter, divisor register, registered strobe
// and waveform, and a lock qualifier that counts completed periods.
module clk_div_chan
    import clk_div_pkg::*;
#(
    parameter int DIVW     = PKG_DIVW,
    parameter int DEF_DIV  = PKG_DEF_DIV,
    parameter int LOCK_CYC = PKG_LOCK_CYC
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_lk,
    input  logic            i_sync,
    input  logic            i_apply_req,
    input  logic [DIVW-1:0] i_new_div,
    output logic            o_applied,
    output logic            o_ce,
    output logic            o_div,
    output logic            o_locked
);

    localparam int              LCW       = (LOCK_CYC > 0) ? $clog2(LOCK_CYC + 1) : 1;
    localparam logic [LCW-1:0]  LOCK_INIT = LCW'(LOCK_CYC);
    localparam logic [DIVW-1:0] ONE       = DIVW'(1);
    localparam logic [DIVW-1:0] TWO       = DIVW'(2);

    logic [DIVW-1:0] r_cnt;
    logic [DIVW-1:0] r_div;
    logic            r_run;
    logic [LCW-1:0]  r_lock_cnt;
    logic            r_ce;
    logic            r_wave;
    logic            r_locked;

    logic            w_wrap;
    logic            w_boundary;
    logic            w_apply;
    logic            w_restart;
    logic [DIVW-1:0] w_div_nx;
    logic [DIVW-1:0] w_cnt_nx;
    logic [DIVW-1:0] w_half;

    // Period boundary detection and next-state of counter/divisor.
    // r_run is only set while lk=1 and D/=0, so !r_run covers both idle cases.
    always_comb begin
        w_wrap     = (r_cnt == r_div - ONE);
        w_boundary = !i_lk || !r_run || w_wrap || i_sync;
        w_apply    = i_apply_req && w_boundary;
        w_div_nx   = w_apply ? i_new_div : r_div;
        w_restart  = !r_run || w_wrap || i_sync || w_apply;
        w_cnt_nx   = w_restart ? '0 : r_cnt + ONE;
        w_half     = (w_div_nx >> 1) + DIVW'(w_div_nx[0]);
    end

    // Counter, divisor, registered outputs and lock qualification.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_cnt      <= '0;
            r_div      <= DIVW'(DEF_DIV);
            r_run      <= 1'b0;
            r_lock_cnt <= LOCK_INIT;
            r_ce       <= 1'b0;
            r_wave     <= 1'b0;
            r_locked   <= 1'b0;
        end else if (!i_lk || (w_div_nx == '0)) begin
            r_div      <= w_div_nx;
            r_cnt      <= '0;
            r_run      <= 1'b0;
            r_lock_cnt <= LOCK_INIT;
            r_ce       <= 1'b0;
            r_wave     <= 1'b0;
            r_locked   <= 1'b0;
        end else begin
            r_div  <= w_div_nx;
            r_cnt  <= w_cnt_nx;
            r_run  <= 1'b1;
            r_ce   <= (w_cnt_nx == '0);
            r_wave <= (w_div_nx >= TWO) && (w_cnt_nx < w_half);
            if (w_apply || !r_run) begin
                r_lock_cnt <= LOCK_INIT;
                r_locked   <= (LOCK_CYC == 0);
            end else if (w_wrap && (r_lock_cnt != '0)) begin
                r_lock_cnt <= r_lock_cnt - LCW'(1);
                if (r_lock_cnt == LCW'(1)) r_locked <= 1'b1;
            end
        end
    end

    assign o_applied = w_apply;
    assign o_ce      = r_ce;
    assign o_div     = r_wave;
    assign o_locked  = r_locked;

endmodule

// File: rtl/clk_div_multi.sv
// Multi-channel runtime-programmable clock divider. Holds the lock
// synchroniser, the single-entry config slot and its handshake.
// Optional macro CLKDIV_SYNC_EN adds i_sync_in, which restarts every enabled
// channel at cnt=0 on the following cycle.
module clk_div_multi
    import clk_div_pkg::*;
#(
    parameter int  NCH      = PKG_NCH,
    parameter int  DIVW     = PKG_DIVW,
    parameter int  DEF_DIV  = PKG_DEF_DIV,
    parameter int  LOCK_CYC = PKG_LOCK_CYC,
    parameter int  SYNC_ST  = PKG_SYNC_ST,
    localparam int CHW      = ch_width(NCH)
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_ext_locked,
    input  logic            i_cfg_valid,
    output logic            o_cfg_ready,
    input  logic [CHW-1:0]  i_cfg_ch,
    input  logic [DIVW-1:0] i_cfg_div,
    output logic [NCH-1:0]  o_ce_out,
    output logic [NCH-1:0]  o_div_out,
    output logic [NCH-1:0]  o_ch_locked
`ifdef CLKDIV_SYNC_EN
    ,
    input  logic            i_sync_in
`endif
);

    logic [SYNC_ST-1:0] r_sync;
    logic               r_cfg_ready;
    cfg_req_t           r_slot;

    logic               w_lk;
    logic               w_sync;
    logic               w_ch_ok;
    logic [NCH-1:0]     w_applied;

    assign w_lk    = r_sync[SYNC_ST-1];
    assign w_ch_ok = (32'(i_cfg_ch) < NCH);

`ifdef CLKDIV_SYNC_EN
    assign w_sync = i_sync_in && w_lk;
`else
    assign w_sync = 1'b0;
`endif

    // Bring the asynchronous upstream lock into the fabric clock domain.
    always_ff @(posedge i_clk) begin
        if (i_rst) r_sync <= '0;
        else       r_sync <= {r_sync[SYNC_ST-2:0], i_ext_locked};
    end

    // Single shadow slot: r_cfg_ready low means an update is pending.
    // Requests to non-existent channels complete the handshake and are dropped.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_cfg_ready <= 1'b1;
            r_slot      <= '0;
        end else if (!r_cfg_ready) begin
            if (|w_applied) r_cfg_ready <= 1'b1;
        end else if (i_cfg_valid && w_ch_ok) begin
            r_slot.ch   <= CFG_CHW_MAX'(i_cfg_ch);
            r_slot.div  <= CFG_DIVW_MAX'(i_cfg_div);
            r_cfg_ready <= 1'b0;
        end
    end

    assign o_cfg_ready = r_cfg_ready;

    for (genvar gi = 0; gi < NCH; gi++) begin : g_ch
        clk_div_chan #(
            .DIVW     (DIVW),
            .DEF_DIV  (DEF_DIV),
            .LOCK_CYC (LOCK_CYC)
        ) u_chan (
            .i_clk       (i_clk),
            .i_rst       (i_rst),
            .i_lk        (w_lk),
            .i_sync      (w_sync),
            .i_apply_req (!r_cfg_ready && (r_slot.ch == CFG_CHW_MAX'(gi))),
            .i_new_div   (DIVW'(r_slot.div)),
            .o_applied   (w_applied[gi]),
            .o_ce        (o_ce_out[gi]),
            .o_div       (o_div_out[gi]),
            .o_locked    (o_ch_locked[gi])
        );
    end

endmodule

// File: tb/tb_clk_div_multi.sv
// Directed bench for clk_div_multi (3 channels so an out-of-range channel
// index is representable on the 2-bit cfg_ch port).
module tb_clk_div_multi;

    logic        clk = 1'b0;
    logic        rst;
    logic        ext_locked;
    logic        cfg_valid;
    logic        cfg_ready;
    logic [1:0]  cfg_ch;
    logic [15:0] cfg_div;
    logic [2:0]  ce;
    logic [2:0]  dv;
    logic [2:0]  lkd;
`ifdef CLKDIV_SYNC_EN
    logic        sync_in;
`endif

    int n_cmp = 0;
    int n_err = 0;

    logic [31:0] c0, c1, d0, d1;

    always #5 clk = ~clk;

    clk_div_multi #(
        .NCH      (3),
        .DIVW     (16),
        .DEF_DIV  (4),
        .LOCK_CYC (4),
        .SYNC_ST  (2)
    ) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_ext_locked (ext_locked),
        .i_cfg_valid  (cfg_valid),
        .o_cfg_ready  (cfg_ready),
        .i_cfg_ch     (cfg_ch),
        .i_cfg_div    (cfg_div),
        .o_ce_out     (ce),
        .o_div_out    (dv),
        .o_ch_locked  (lkd)
`ifdef CLKDIV_SYNC_EN
        ,
        .i_sync_in    (sync_in)
`endif
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Collect n samples of ch0/ch1 strobe and waveform, first sample in the MSB.
    task automatic trace(input int n, output logic [31:0] t_c0, output logic [31:0] t_c1,
                         output logic [31:0] t_d0, output logic [31:0] t_d1);
        t_c0 = '0; t_c1 = '0; t_d0 = '0; t_d1 = '0;
        for (int i = 0; i < n; i++) begin
            tick;
            t_c0 = {t_c0[30:0], ce[0]};
            t_c1 = {t_c1[30:0], ce[1]};
            t_d0 = {t_d0[30:0], dv[0]};
            t_d1 = {t_d1[30:0], dv[1]};
        end
    endtask

    task automatic cfg_write(input logic [1:0] ch, input logic [15:0] d);
        cfg_valid = 1'b1;
        cfg_ch    = ch;
        cfg_div   = d;
        tick;
        cfg_valid = 1'b0;
    endtask

    task automatic wait_ready(input string tag);
        int k = 0;
        while (!cfg_ready && k < 64) begin
            tick;
            k++;
        end
        check(tag, 32'(cfg_ready), 32'd1);
    endtask

    task automatic wait_ce0(input string tag);
        int k = 0;
        while (!ce[0] && k < 32) begin
            tick;
            k++;
        end
        check(tag, 32'(ce[0]), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst        = 1'b1;
        ext_locked = 1'b1;
        cfg_valid  = 1'b0;
        cfg_ch     = '0;
        cfg_div    = '0;
`ifdef CLKDIV_SYNC_EN
        sync_in    = 1'b0;
`endif

        // Reset and start-up with DEF_DIV=4
        tick;
        check("rst_ce",    32'(ce),        32'd0);
        check("rst_div",   32'(dv),        32'd0);
        check("rst_lock",  32'(lkd),       32'd0);
        check("rst_ready", 32'(cfg_ready), 32'd1);
        rst = 1'b0;
        tick;
        tick;
        check("sync_latency_ce", 32'(ce), 32'd0);
        trace(16, c0, c1, d0, d1);
        check("t1_ce0",  c0, 32'h8888);
        check("t1_div0", d0, 32'hcccc);
        check("t1_ce1",  c1, 32'h8888);
        check("t1_div1", d1, 32'hcccc);
        check("t1_lock_early", 32'(lkd), 32'd0);
        tick;
        check("t1_lock", 32'(lkd), 32'b111);

        // ch0 4 -> 5 mid-period; switch lands exactly on the wrap
        cfg_write(2'd0, 16'd5);
        check("t2_ready_busy", 32'(cfg_ready), 32'd0);
        check("t2_lock_held",  32'(lkd[0]),    32'd1);
        trace(12, c0, c1, d0, d1);
        check("t2_ce0",  c0, 32'b0010_0001_0000);
        check("t2_div0", d0, 32'b0011_1001_1100);
        check("t2_ready_back", 32'(cfg_ready), 32'd1);
        check("t2_lock_drop",  32'(lkd[0]),    32'd0);
        repeat (10) tick;
        check("t2_relock_early", 32'(lkd[0]), 32'd0);
        tick;
        check("t2_relock", 32'(lkd), 32'b111);

        // ch1: D=3, D=1, D=0, then an out-of-range channel
        cfg_write(2'd1, 16'd3);
        wait_ready("t3_d3_apply");
        check("t3_d3_first_ce", 32'(ce[1]), 32'd1);
        check("t3_d3_first_dv", 32'(dv[1]), 32'd1);
        trace(9, c0, c1, d0, d1);
        check("t3_d3_ce",  c1, 32'b001001001);
        check("t3_d3_div", d1, 32'b101101101);

        cfg_write(2'd1, 16'd1);
        wait_ready("t3_d1_apply");
        trace(6, c0, c1, d0, d1);
        check("t3_d1_ce",   c1, 32'b111111);
        check("t3_d1_div",  d1, 32'b000000);
        check("t3_d1_lock", 32'(lkd[1]), 32'd1);

        cfg_write(2'd1, 16'd0);
        wait_ready("t3_d0_apply");
        trace(6, c0, c1, d0, d1);
        check("t3_d0_ce",   c1, 32'd0);
        check("t3_d0_div",  d1, 32'd0);
        check("t3_d0_lock", 32'(lkd[1]), 32'd0);

        cfg_write(2'd3, 16'd7);
        check("t3_badch_ready", 32'(cfg_ready), 32'd1);
        trace(8, c0, c1, d0, d1);
        check("t3_badch_ce1",  c1, 32'd0);
        check("t3_badch_lock", 32'(lkd), 32'b101);

        // Lock drop with an update pending, then relock
        wait_ce0("t4_align");
        ext_locked = 1'b0;
        cfg_write(2'd0, 16'd2);
        tick;
        check("t4_still_running", 32'(dv[0]),    32'd1);
        check("t4_pending",       32'(cfg_ready), 32'd0);
        tick;
        check("t4_off_ce",    32'(ce),        32'd0);
        check("t4_off_div",   32'(dv),        32'd0);
        check("t4_off_lock",  32'(lkd),       32'd0);
        check("t4_off_ready", 32'(cfg_ready), 32'd1);
        ext_locked = 1'b1;
        tick;
        tick;
        check("t4_relock_latency", 32'(ce), 32'd0);
        trace(6, c0, c1, d0, d1);
        check("t4_ce0",  c0, 32'b101010);
        check("t4_div0", d0, 32'b101010);
        check("t4_ce1",  c1, 32'd0);

        // Reset with an update pending
        wait_ce0("t5_align");
        cfg_write(2'd0, 16'd9);
        rst = 1'b1;
        tick;
        check("t5_ce",    32'(ce),        32'd0);
        check("t5_div",   32'(dv),        32'd0);
        check("t5_lock",  32'(lkd),       32'd0);
        check("t5_ready", 32'(cfg_ready), 32'd1);
        rst = 1'b0;
        tick;
        tick;
        trace(8, c0, c1, d0, d1);
        check("t5_ce0",  c0, 32'b10001000);
        check("t5_div0", d0, 32'b11001100);
        check("t5_ce1",  c1, 32'b10001000);
        check("t5_div1", d1, 32'b11001100);

`ifdef CLKDIV_SYNC_EN
        // Phase realign across channels of different divisors
        cfg_write(2'd1, 16'd6);
        wait_ready("t6_d6_apply");
        repeat (30) tick;
        check("t6_pre_lock", 32'(lkd), 32'b111);
        sync_in = 1'b1;
        tick;
        sync_in = 1'b0;
        check("t6_ce_all", 32'(ce),  32'b111);
        check("t6_lock",   32'(lkd), 32'b111);
        trace(6, c0, c1, d0, d1);
        check("t6_ce0", c0, 32'b000100);
        check("t6_ce1", c1, 32'b000001);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
